stack_access_unit: RTL and testbench

Memory-stage controller that consumes the stack pointer value delivered through the pipeline buffer by the SP stage and performs 32-bit push/pop transfers against the 16-bit-wide data memory. Each 32-bit access is split into two half-word accesses at A and A+1, where A is the buffered SP value. The unit stalls the pipeline while an access is in flight and flags out-of-range stack addresses. It sits between the execute/memory buffer and the data memory port, and feeds the memory/write-back buffer.

---
 rtl/stack_access_unit_pkg.sv | 14 +
 rtl/stack_access_unit_if.sv | 31 +++
 rtl/stack_access_unit_register_32bit.sv | 16 +
 rtl/stack_access_unit.sv | 124 ++++++++++++
 tb/tb_stack_access_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/stack_access_unit_pkg.sv
// Shared definitions for the stack access unit: FSM encoding and memory geometry.
package stack_access_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int HALF_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PUSH_HI  = 2'd1,
        ST_POP_HI   = 2'd2,
        ST_POP_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/stack_access_unit_if.sv
// Request side (from the execute/memory buffer) and data memory port of the stack access unit.
interface stack_access_unit_if
    import stack_access_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              Enable;
    logic              PushSignal;
    logic              popSignal;
    logic [31:0]       SPfromBuffer;
    logic [31:0]       PushData;
    logic [HALF_W-1:0] MemReadData;
    logic [ADDR_W-1:0] MemAddr;
    logic [HALF_W-1:0] MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic              Stall;
    logic [31:0]       PopData;
    logic              PopValid;
    logic              Error;

    modport slave (
        input  Enable, PushSignal, popSignal, SPfromBuffer, PushData, MemReadData,
        output MemAddr, MemWriteData, MemWrite, MemRead, Stall, PopData, PopValid, Error
    );

    modport master (
        output Enable, PushSignal, popSignal, SPfromBuffer, PushData, MemReadData,
        input  MemAddr, MemWriteData, MemWrite, MemRead, Stall, PopData, PopValid, Error
    );
endinterface

// File: rtl/stack_access_unit_register_32bit.sv
// Generic 32-bit load-enabled register with synchronous active-high clear.
module register_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/stack_access_unit.sv
// Splits 32-bit stack push/pop into two half-word accesses at A and A+1,
// stalling the pipeline while the access is in flight.
module stack_access_unit
    import stack_access_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic               CLK,
    input logic               Reset,
    stack_access_unit_if.slave bus
);
    // state | meaning
    // IDLE     | waiting for a request; issues the low half-access on accept
    // PUSH_HI  | writing the high half at A+1
    // POP_HI   | reading A+1, capturing mem[A] into the low register
    // POP_DONE | presenting the assembled word with PopValid
    state_t state;

    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_next;
    logic              range_bad;
    logic              conflict;
    logic              req;
    logic              accept_push;
    logic              accept_pop;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [31:0]       data_d;
    logic              data_load;

    assign addr_a    = bus.SPfromBuffer[ADDR_W-1:0];
    assign addr_next = addr_a + {{(ADDR_W-1){1'b0}}, 1'b1};
    // The top address is rejected so that A+1 can never wrap back to 0.
    assign range_bad = (|bus.SPfromBuffer[31:ADDR_W]) || (&addr_a);
    assign conflict  = bus.PushSignal && bus.popSignal;
    assign req       = (state == ST_IDLE) && bus.Enable && (bus.PushSignal || bus.popSignal);
    assign accept_push = req && bus.PushSignal && !bus.popSignal && !range_bad;
    assign accept_pop  = req && bus.popSignal && !bus.PushSignal && !range_bad;

    // One register serves as push high half or popped low half; their lifetimes never overlap.
    assign data_load = accept_push || (state == ST_POP_HI);
    assign data_d    = accept_push ? {{(32-HALF_W){1'b0}}, bus.PushData[31:HALF_W]}
                                   : {{(32-HALF_W){1'b0}}, bus.MemReadData};

    register_32bit u_addr_reg (
        .clk   (CLK),
        .reset (Reset),
        .load  (accept_push || accept_pop),
        .d     ({{(32-ADDR_W){1'b0}}, addr_next}),
        .q     (addr_q)
    );

    register_32bit u_data_reg (
        .clk   (CLK),
        .reset (Reset),
        .load  (data_load),
        .d     (data_d),
        .q     (data_q)
    );

    logic unused_bits;
    assign unused_bits = &{1'b0, addr_q[31:ADDR_W], data_q[31:HALF_W]};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_push) begin
                        state <= ST_PUSH_HI;
                    end else if (accept_pop) begin
                        state <= ST_POP_HI;
                    end
                end
                ST_PUSH_HI:  state <= ST_IDLE;
                ST_POP_HI:   state <= ST_POP_DONE;
                ST_POP_DONE: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.MemAddr      = '0;
        bus.MemWriteData = '0;
        bus.MemWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.Stall        = 1'b0;
        bus.PopData      = '0;
        bus.PopValid     = 1'b0;
        bus.Error        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.Error = req && (conflict || range_bad);
                if (accept_push) begin
                    bus.MemWrite     = 1'b1;
                    bus.MemAddr      = addr_a;
                    bus.MemWriteData = bus.PushData[HALF_W-1:0];
                    bus.Stall        = 1'b1;
                end else if (accept_pop) begin
                    bus.MemRead = 1'b1;
                    bus.MemAddr = addr_a;
                    bus.Stall   = 1'b1;
                end
            end
            ST_PUSH_HI: begin
                bus.MemWrite     = 1'b1;
                bus.MemAddr      = addr_q[ADDR_W-1:0];
                bus.MemWriteData = data_q[HALF_W-1:0];
            end
            ST_POP_HI: begin
                bus.MemRead = 1'b1;
                bus.MemAddr = addr_q[ADDR_W-1:0];
                bus.Stall   = 1'b1;
            end
            ST_POP_DONE: begin
                bus.PopValid = 1'b1;
                bus.PopData  = {bus.MemReadData, data_q[HALF_W-1:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_stack_access_unit.sv
// Self-checking bench for stack_access_unit: directed and random push/pop traffic
// against a word-level shadow memory.
module tb_stack_access_unit;
    import stack_access_unit_pkg::*;

    localparam int AW = 12;

    logic CLK = 1'b0;
    logic Reset;

    stack_access_unit_if #(.ADDR_W(AW)) bus ();

    stack_access_unit #(.ADDR_W(AW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port half-word RAM, one cycle read latency.
    logic [15:0] mem [0:4095];
    always @(posedge CLK) begin
        if (bus.MemWrite) mem[bus.MemAddr] <= bus.MemWriteData;
        if (bus.MemRead) bus.MemReadData <= mem[bus.MemAddr];
    end

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] ref_mem [0:4095];
    logic [11:0] pushed [$];

    function automatic logic [64:0] pk(input logic mw, input logic mr, input logic st,
                                       input logic pv, input logic er, input logic [11:0] ad,
                                       input logic [15:0] wd, input logic [31:0] pd);
        return {mw, mr, st, pv, er, ad, wd, pd};
    endfunction

    task automatic set_in(input logic en, input logic pu, input logic po,
                          input logic [31:0] sp, input logic [31:0] pd);
        bus.Enable       = en;
        bus.PushSignal   = pu;
        bus.popSignal    = po;
        bus.SPfromBuffer = sp;
        bus.PushData     = pd;
    endtask

    task automatic chk_only(input string tag, input logic [64:0] expv);
        logic [64:0] obs;
        @(negedge CLK);
        obs = pk(bus.MemWrite, bus.MemRead, bus.Stall, bus.PopValid, bus.Error,
                 bus.MemAddr, bus.MemWriteData, bus.PopData);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] expv);
        chk_only(tag, expv);
        adv();
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[31:12] != 20'h0) || (a[11:0] == 12'hFFF);
    endfunction

    // Inputs stay held through the whole operation, as a stalled upstream would hold them.
    task automatic do_push(input logic [31:0] a, input logic [31:0] d);
        logic [11:0] lo;
        logic [11:0] hi;
        lo = a[11:0];
        hi = lo + 12'd1;
        set_in(1'b1, 1'b1, 1'b0, a, d);
        if (is_bad(a)) begin
            chk("push_err", pk(0, 0, 0, 0, 1, 12'h0, 16'h0, 32'h0));
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("push_err_idle", 65'h0);
        end else begin
            chk("push_lo", pk(1, 0, 1, 0, 0, lo, d[15:0], 32'h0));
            chk("push_hi", pk(1, 0, 0, 0, 0, hi, d[31:16], 32'h0));
            ref_mem[lo] = d[15:0];
            ref_mem[hi] = d[31:16];
            pushed.push_back(lo);
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic do_pop(input logic [31:0] a);
        logic [11:0] lo;
        logic [11:0] hi;
        lo = a[11:0];
        hi = lo + 12'd1;
        set_in(1'b1, 1'b0, 1'b1, a, $urandom);
        if (is_bad(a)) begin
            chk("pop_err", pk(0, 0, 0, 0, 1, 12'h0, 16'h0, 32'h0));
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("pop_err_idle", 65'h0);
        end else begin
            chk("pop_rd_lo", pk(0, 1, 1, 0, 0, lo, 16'h0, 32'h0));
            chk("pop_rd_hi", pk(0, 1, 1, 0, 0, hi, 16'h0, 32'h0));
            chk("pop_done", pk(0, 0, 0, 1, 0, 12'h0, 16'h0, {ref_mem[hi], ref_mem[lo]}));
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int sel;
        int idx;

        Reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        adv();
        chk("reset", 65'h0);
        Reset = 1'b0;

        do_push(32'h0000_0010, 32'hDEAD_BEEF);
        chk("push_then_idle", 65'h0);
        do_pop(32'h0000_0010);
        chk("pop_then_idle", 65'h0);

        do_push(32'h0000_0FFF, 32'h1234_5678);
        do_push(32'h0000_1000, 32'h1234_5678);
        do_pop(32'h0000_0FFF);
        do_push(32'h0000_0FFE, 32'hCAFE_F00D);
        do_pop(32'h0000_0FFE);

        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA);
        chk("conflict", pk(0, 0, 0, 0, 1, 12'h0, 16'h0, 32'h0));
        set_in(1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h5555_AAAA);
        chk("enable_no_req", 65'h0);
        set_in(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h5555_AAAA);
        chk("disabled_push", 65'h0);

        // Back-to-back push then pop with no idle cycle between.
        do_push(32'h0000_0100, 32'h0BAD_C0DE);
        do_pop(32'h0000_0100);

        // Reset lands while the pop is in POP_HI.
        set_in(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        chk("rst_pop_lo", pk(0, 1, 1, 0, 0, 12'h010, 16'h0, 32'h0));
        chk_only("rst_pop_hi", pk(0, 1, 1, 0, 0, 12'h011, 16'h0, 32'h0));
        Reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        adv();
        Reset = 1'b0;
        chk("rst_after", 65'h0);
        chk("rst_no_popvalid", 65'h0);
        do_pop(32'h0000_0010);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4 || pushed.size() == 0) begin
                a = {20'h0, 12'($urandom_range(0, 4094))};
                d = $urandom;
                do_push(a, d);
            end else if (sel <= 7) begin
                idx = $urandom_range(0, pushed.size() - 1);
                do_pop({20'h0, pushed[idx]});
            end else if (sel == 8) begin
                a = ($urandom_range(0, 1) == 0) ? 32'h0000_0FFF
                                                : {20'($urandom_range(1, 1048575)), 12'($urandom)};
                if ($urandom_range(0, 1) == 0) do_push(a, $urandom);
                else do_pop(a);
            end else begin
                set_in(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
                chk("rand_idle", 65'h0);
                set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("final_idle", 65'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
